// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single SRAM port.
// Each access holds address, data and one strobe for ACC_CYCLES cycles.
module sram_arbiter #(
    parameter int ACC_CYCLES = 3,
    parameter int AW         = 16,
    parameter int DW         = 16
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          we0,
    input  logic          we1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata,
    output logic [AW-1:0] ADDR,
    output logic [DW-1:0] Data_to_SRAM,
    output logic          OE,
    output logic          WE,
    input  logic [DW-1:0] Data_from_SRAM,
    output logic          busy,
    output logic          owner
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_RESP
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(ACC_CYCLES - 1);

    state_t        r_state;
    state_t        w_next;
    logic          r_last;
    logic          r_we;
    logic [3:0]    r_cnt;
    logic          w_any;
    logic          w_win;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;

    // On a tie the port that did not finish last wins
    assign w_any   = req0 | req1;
    assign w_win   = (req0 & req1) ? ~r_last : req1;
    assign w_we    = w_win ? we1 : we0;
    assign w_addr  = w_win ? addr1 : addr0;
    assign w_wdata = w_win ? wdata1 : wdata0;
    assign busy    = (r_state != S_IDLE);

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_any) begin
                    w_next = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_last       <= 1'b1;
            r_we         <= 1'b0;
            r_cnt        <= 4'd0;
            owner        <= 1'b0;
            ADDR         <= '0;
            Data_to_SRAM <= '0;
            rdata        <= '0;
            OE           <= 1'b0;
            WE           <= 1'b0;
            done0        <= 1'b0;
            done1        <= 1'b0;
        end else begin
            done0 <= 1'b0;
            done1 <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        owner        <= w_win;
                        r_we         <= w_we;
                        ADDR         <= w_addr;
                        Data_to_SRAM <= w_wdata;
                        OE           <= ~w_we;
                        WE           <= w_we;
                        r_cnt        <= CNT_INIT;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        if (!r_we) begin
                            rdata <= Data_from_SRAM;
                        end
                        OE    <= 1'b0;
                        WE    <= 1'b0;
                        done0 <= ~owner;
                        done1 <= owner;
                    end
                end
                S_RESP: begin
                    r_last <= owner;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transaction-level timing model checked every
// cycle, directed scenarios with literal expectations, random traffic.
module tb_sram_arbiter;

    localparam int ACC = 3;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        req0, req1, we0, we1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        done0, done1, OE, WE, busy, owner;
    logic [15:0] rdata, ADDR, Data_to_SRAM, Data_from_SRAM;

    logic        b_req0, b_req1, b_we0, b_we1;
    logic [15:0] b_addr0, b_addr1, b_wdata0, b_wdata1;
    logic        b_done0, b_done1, b_OE, b_WE, b_busy, b_owner;
    logic [15:0] b_rdata, b_ADDR, b_DTS, b_DFS;

    always #5 Clk = ~Clk;

    sram_arbiter #(.ACC_CYCLES(ACC), .AW(16), .DW(16)) dut (
        .Clk(Clk), .Reset(Reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .done0(done0), .done1(done1), .rdata(rdata),
        .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .OE(OE), .WE(WE),
        .Data_from_SRAM(Data_from_SRAM), .busy(busy), .owner(owner)
    );

    sram_arbiter #(.ACC_CYCLES(1), .AW(16), .DW(16)) u_fast (
        .Clk(Clk), .Reset(Reset),
        .req0(b_req0), .req1(b_req1), .we0(b_we0), .we1(b_we1),
        .addr0(b_addr0), .addr1(b_addr1),
        .wdata0(b_wdata0), .wdata1(b_wdata1),
        .done0(b_done0), .done1(b_done1), .rdata(b_rdata),
        .ADDR(b_ADDR), .Data_to_SRAM(b_DTS), .OE(b_OE), .WE(b_WE),
        .Data_from_SRAM(b_DFS), .busy(b_busy), .owner(b_owner)
    );

    assign b_DFS = b_ADDR ^ 16'h5A5A;

    function automatic logic [15:0] pat(input logic [7:0] a);
        return (a == 8'h10) ? 16'hBEEF : {a, ~a};
    endfunction

    // SRAM: untouched locations read back a fixed pattern
    logic [15:0]  sram [256];
    logic [255:0] sram_wr = '0;
    assign Data_from_SRAM = sram_wr[ADDR[7:0]] ? sram[ADDR[7:0]]
                                                : pat(ADDR[7:0]);
    always @(posedge Clk) begin
        if (WE) begin
            sram[ADDR[7:0]]    <= Data_to_SRAM;
            sram_wr[ADDR[7:0]] <= 1'b1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    // Model: m_n counts cycles since the grant edge, 0 = free
    int           m_n = 0;
    logic         m_last = 1'b1, m_owner = 1'b0, m_we = 1'b0;
    logic [15:0]  m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic [15:0]  m_mem [256];
    logic [255:0] m_wr = '0;

    function automatic logic [15:0] mem_rd(input logic [7:0] a);
        return m_wr[a] ? m_mem[a] : pat(a);
    endfunction

    always @(negedge Clk) begin
        logic strobe;
        if (!Reset) begin
            m_n = 0; m_last = 1'b1; m_owner = 1'b0; m_we = 1'b0;
            m_addr = '0; m_wdata = '0; m_rdata = '0;
        end else if (m_n != 0) begin
            if (m_n == ACC && !m_we) m_rdata = mem_rd(m_addr[7:0]);
            if (m_n == ACC + 1) begin
                m_last = m_owner;
                m_n = 0;
            end else begin
                m_n++;
            end
        end else if (req0 || req1) begin
            m_owner = (req0 && req1) ? !m_last : req1;
            m_we    = m_owner ? we1 : we0;
            m_addr  = m_owner ? addr1 : addr0;
            m_wdata = m_owner ? wdata1 : wdata0;
            if (m_we) begin
                m_mem[m_addr[7:0]] = m_wdata;
                m_wr[m_addr[7:0]]  = 1'b1;
            end
            m_n = 1;
        end
        strobe = (m_n >= 1) && (m_n <= ACC);
        chk("OE", OE, strobe && !m_we);
        chk("WE", WE, strobe && m_we);
        chk("excl", OE && WE, 1'b0);
        chk("ADDR", ADDR, m_addr);
        chk("Data_to_SRAM", Data_to_SRAM, m_wdata);
        chk("done0", done0, (m_n == ACC + 1) && !m_owner);
        chk("done1", done1, (m_n == ACC + 1) && m_owner);
        chk("rdata", rdata, m_rdata);
        chk("busy", busy, m_n != 0);
        chk("owner", owner, m_owner);
    end

    task automatic cyc();
        @(negedge Clk);
        #1;
    endtask

    task automatic drive(input bit p, input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d);
        if (p) begin
            req1 = r; we1 = w; addr1 = a; wdata1 = d;
        end else begin
            req0 = r; we0 = w; addr0 = a; wdata0 = d;
        end
    endtask

    task automatic run_one(input bit p, input logic w,
                           input logic [15:0] a, input logic [15:0] d,
                           input bit abort, output int oe_n,
                           output int we_n, output int done_at,
                           output logic [15:0] rd, output logic [15:0] adr,
                           output logic [15:0] dts);
        oe_n = 0; we_n = 0; done_at = -1; rd = '0; adr = '0; dts = '0;
        drive(p, 1'b1, w, a, d);
        for (int i = 1; i <= 20; i++) begin
            cyc();
            if (OE) oe_n++;
            if (WE) we_n++;
            if (OE || WE) begin
                adr = ADDR;
                dts = Data_to_SRAM;
            end
            if (abort && i == 2) drive(p, 1'b0, w, a ^ 16'h1, ~d);
            if (p ? done1 : done0) begin
                done_at = i;
                rd = rdata;
                break;
            end
        end
        drive(p, 1'b0, w, a, d);
        cyc();
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int oe_n, we_n, dat, nd, first, seen;
        int ord [4];
        int tm [4];
        logic [15:0] rd, adr, dts;

        req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        b_req0 = 0; b_req1 = 0; b_we0 = 0; b_we1 = 0;
        b_addr0 = '0; b_addr1 = '0; b_wdata0 = '0; b_wdata1 = '0;
        repeat (3) cyc();
        chk("rst_OE", OE, 0);
        chk("rst_WE", WE, 0);
        chk("rst_ADDR", ADDR, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", {done0, done1}, 0);
        Reset = 1'b1;
        cyc();

        run_one(0, 0, 16'h0010, 16'h0, 0, oe_n, we_n, dat, rd, adr, dts);
        chk("rd_oe_cycles", oe_n, 3);
        chk("rd_we_cycles", we_n, 0);
        chk("rd_done_at", dat, 4);
        chk("rd_data", rd, 16'hBEEF);
        chk("rd_addr", adr, 16'h0010);

        run_one(1, 1, 16'h0005, 16'h1234, 0, oe_n, we_n, dat, rd, adr, dts);
        chk("wr_we_cycles", we_n, 3);
        chk("wr_oe_cycles", oe_n, 0);
        chk("wr_done_at", dat, 4);
        chk("wr_data", dts, 16'h1234);
        run_one(0, 0, 16'h0005, 16'h0, 0, oe_n, we_n, dat, rd, adr, dts);
        chk("wr_readback", rd, 16'h1234);

        Reset = 1'b0;
        cyc();
        Reset = 1'b1;
        cyc();
        drive(0, 1'b1, 1'b0, 16'h0020, 16'h0);
        drive(1, 1'b1, 1'b0, 16'h0021, 16'h0);
        nd = 0;
        for (int i = 1; i <= 40; i++) begin
            cyc();
            if (done0 || done1) begin
                ord[nd] = done1 ? 1 : 0;
                tm[nd] = i;
                nd++;
                if (nd == 4) break;
            end
        end
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        cyc();
        chk("rr_count", nd, 4);
        if (nd == 4) begin
            chk("rr_first_at", tm[0], 4);
            for (int j = 0; j < 4; j++) chk("rr_order", ord[j], j % 2);
            for (int j = 0; j < 3; j++) chk("rr_gap", tm[j+1] - tm[j], 5);
        end

        run_one(0, 0, 16'h0030, 16'h0, 1, oe_n, we_n, dat, rd, adr, dts);
        chk("abort_addr", adr, 16'h0030);
        chk("abort_oe_cycles", oe_n, 3);
        chk("abort_done_at", dat, 4);

        drive(0, 1'b1, 1'b0, 16'h0040, 16'h0);
        cyc();
        cyc();
        Reset = 1'b0;
        #1;
        chk("mid_rst_OE", OE, 0);
        chk("mid_rst_WE", WE, 0);
        chk("mid_rst_busy", busy, 0);
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        seen = 0;
        repeat (3) begin
            cyc();
            if (done0 || done1) seen++;
        end
        chk("mid_rst_no_done", seen, 0);
        Reset = 1'b1;
        drive(0, 1'b1, 1'b0, 16'h0041, 16'h0);
        drive(1, 1'b1, 1'b0, 16'h0042, 16'h0);
        first = -1;
        for (int i = 1; i <= 15; i++) begin
            cyc();
            if (done0 || done1) begin
                first = done1 ? 1 : 0;
                break;
            end
        end
        drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        cyc();
        chk("post_rst_tie", first, 0);
        repeat (8) cyc();

        b_req0 = 1'b1;
        b_addr0 = 16'h0077;
        nd = 0;
        oe_n = 0;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (b_OE && nd == 0) oe_n++;
            if (b_done0) begin
                tm[nd] = i;
                if (nd == 0) rd = b_rdata;
                nd++;
                if (nd == 2) break;
            end
        end
        b_req0 = 1'b0;
        cyc();
        chk("fast_count", nd, 2);
        chk("fast_oe_cycles", oe_n, 1);
        chk("fast_done_at", tm[0], 2);
        chk("fast_rdata", rd, 16'h0077 ^ 16'h5A5A);
        if (nd == 2) chk("fast_gap", tm[1] - tm[0], 3);

        nd = 0;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            for (int p = 0; p < 2; p++) begin
                logic r, dn;
                r  = p[0] ? req1 : req0;
                dn = p[0] ? done1 : done0;
                if (r && dn) begin
                    nd++;
                    drive(p[0], 1'b0, 1'b0, 16'h0, 16'h0);
                end else if (!r && $urandom_range(0, 3) == 0) begin
                    drive(p[0], 1'b1, 1'($urandom_range(0, 1)),
                          16'($urandom_range(0, 255)), 16'($urandom));
                end else if (r && $urandom_range(0, 7) == 0) begin
                    drive(p[0], 1'b1, 1'($urandom_range(0, 1)),
                          16'($urandom_range(0, 255)), 16'($urandom));
                end
            end
        end
        for (int i = 0; i < 40 && (req0 || req1); i++) begin
            cyc();
            if (req0 && done0) drive(0, 1'b0, 1'b0, 16'h0, 16'h0);
            if (req1 && done1) drive(1, 1'b0, 1'b0, 16'h0, 16'h0);
        end
        chk("drain", {req0, req1}, 2'b00);
        chk("rand_traffic", nd > 100, 1'b1);
        repeat (4) cyc();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
